// File: rtl/voq_req_gen.sv
// VOQ occupancy tracker and request generator feeding a priority iSLIP scheduler.
// Launches one scheduling round per start pulse and applies the returned match to the counters.
module voq_req_gen #(
  parameter int N  = 4,
  parameter int P  = 16,
  parameter int C  = $clog2(P),
  parameter int QD = 16,
  parameter int QW = $clog2(QD + 1)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          en,
  input  logic [N-1:0]                  arr_valid,
  input  logic [N-1:0][$clog2(N)-1:0]   arr_dst,
  output logic [N-1:0]                  drop,
  output logic [C-1:0]                  pri_req_out [0:N-1][0:N-1],
  output logic                          start,
  input  logic [N-1:0][N-1:0]           decision,
  input  logic                          decision_ready,
  output logic [N-1:0][N-1:0]           xbar_cfg,
  output logic                          xbar_valid,
  output logic                          decision_err,
  output logic                          busy
);

  localparam int AW = $clog2(N);

  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT} state_t;

  state_t               state_q, state_d;
  logic [QW-1:0]        occ_q [N][N];
  logic [QW-1:0]        occ_d [N][N];
  logic [C-1:0]         pri_q [N][N];
  logic [C-1:0]         pri_d [N][N];
  logic [N-1:0][N-1:0]  xbar_q, xbar_d;
  logic                 xbar_valid_q, xbar_valid_d;
  logic                 decision_err_q, decision_err_d;
  logic [N-1:0]         drop_q, drop_d;
  logic [N-1:0][N-1:0]  dep_match;
  logic [N-1:0]         col_v;
  logic                 dec_ok;

  // Occupancy above the top priority level saturates at P-1.
  function automatic logic [C-1:0] sat_pri(input logic [QW-1:0] occ);
    if (int'(occ) > P - 1) return C'(P - 1);
    return C'(occ);
  endfunction

  // A match is usable only if it is a partial permutation over non-empty VOQs.
  always_comb begin
    dec_ok = 1'b1;
    col_v  = '0;
    for (int i = 0; i < N; i++)
      if ($countones(decision[i]) > 1) dec_ok = 1'b0;
    for (int j = 0; j < N; j++) begin
      for (int i = 0; i < N; i++) col_v[i] = decision[i][j];
      if ($countones(col_v) > 1) dec_ok = 1'b0;
    end
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        if (decision[i][j] && (occ_q[i][j] == '0)) dec_ok = 1'b0;
  end

  always_comb begin
    state_d        = state_q;
    occ_d          = occ_q;
    pri_d          = pri_q;
    xbar_d         = xbar_q;
    xbar_valid_d   = 1'b0;
    decision_err_d = 1'b0;
    drop_d         = '0;
    dep_match      = '0;

    case (state_q)
      IDLE: begin
        if (en) begin
          for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++)
              pri_d[i][j] = sat_pri(occ_q[i][j]);
          state_d = LAUNCH;
        end
      end
      LAUNCH: state_d = WAIT;
      WAIT: begin
        if (decision_ready) begin
          state_d = IDLE;
          if (dec_ok) begin
            dep_match    = decision;
            xbar_d       = decision;
            xbar_valid_d = 1'b1;
          end else begin
            decision_err_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // A simultaneous arrival and departure on one VOQ cancel, even when full.
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        if (arr_valid[i] && (arr_dst[i] == AW'(j)) && !dep_match[i][j]) begin
          if (occ_q[i][j] == QW'(QD)) drop_d[i] = 1'b1;
          else                        occ_d[i][j] = occ_q[i][j] + QW'(1);
        end else if (!(arr_valid[i] && (arr_dst[i] == AW'(j))) && dep_match[i][j]) begin
          occ_d[i][j] = occ_q[i][j] - QW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q        <= IDLE;
      xbar_q         <= '0;
      xbar_valid_q   <= 1'b0;
      decision_err_q <= 1'b0;
      drop_q         <= '0;
      for (int i = 0; i < N; i++)
        for (int j = 0; j < N; j++) begin
          occ_q[i][j] <= '0;
          pri_q[i][j] <= '0;
        end
    end else begin
      state_q        <= state_d;
      occ_q          <= occ_d;
      pri_q          <= pri_d;
      xbar_q         <= xbar_d;
      xbar_valid_q   <= xbar_valid_d;
      decision_err_q <= decision_err_d;
      drop_q         <= drop_d;
    end
  end

  assign pri_req_out  = pri_q;
  assign xbar_cfg     = xbar_q;
  assign xbar_valid   = xbar_valid_q;
  assign decision_err = decision_err_q;
  assign drop         = drop_q;
  assign start        = (state_q == LAUNCH);
  assign busy         = (state_q != IDLE);

endmodule

// File: tb/tb_voq_req_gen.sv
// Randomized scoreboard bench for voq_req_gen: the driver predicts each cycle's outputs
// from a count-based model and a negedge monitor compares them against the DUT.
module tb_voq_req_gen;
  localparam int N  = 4;
  localparam int P  = 16;
  localparam int C  = 4;
  localparam int QD = 16;

  logic                  clk = 1'b0;
  logic                  reset, en, decision_ready;
  logic [N-1:0]          arr_valid, drop;
  logic [N-1:0][1:0]     arr_dst;
  logic [C-1:0]          pri_req_out [0:N-1][0:N-1];
  logic                  start, xbar_valid, decision_err, busy;
  logic [N-1:0][N-1:0]   decision, xbar_cfg;

  voq_req_gen #(.N(N), .P(P), .QD(QD)) dut (
    .clk(clk), .reset(reset), .en(en), .arr_valid(arr_valid), .arr_dst(arr_dst),
    .drop(drop), .pri_req_out(pri_req_out), .start(start), .decision(decision),
    .decision_ready(decision_ready), .xbar_cfg(xbar_cfg), .xbar_valid(xbar_valid),
    .decision_err(decision_err), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [N-1:0]          drop;
    logic                  xv;
    logic                  err;
    logic                  st;
    logic                  bsy;
    logic [N-1:0][N-1:0]   xbar;
    logic [N*N-1:0][C-1:0] pri;
    logic [N*N-1:0][4:0]   occ;
  } exp_t;

  exp_t                expq[$];
  int                  mocc [N][N];
  int                  msnap[N][N];
  logic [N-1:0][N-1:0] mxbar;
  int                  amode;
  int                  checks = 0;
  int                  errors = 0;
  int                  drop2_cnt = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, want, $time);
    end
  endtask

  always @(negedge clk) begin : monitor
    exp_t                  ex;
    logic [N*N-1:0][C-1:0] act_pri;
    logic [N*N-1:0][4:0]   act_occ;
    if (drop[2] === 1'b1) drop2_cnt++;
    if (expq.size() > 0) begin
      ex = expq.pop_front();
      for (int i = 0; i < N; i++)
        for (int j = 0; j < N; j++) begin
          act_pri[i*N+j] = pri_req_out[i][j];
          act_occ[i*N+j] = dut.occ_q[i][j];
        end
      chk("drop",         128'(drop),         128'(ex.drop));
      chk("xbar_valid",   128'(xbar_valid),   128'(ex.xv));
      chk("decision_err", 128'(decision_err), 128'(ex.err));
      chk("start",        128'(start),        128'(ex.st));
      chk("busy",         128'(busy),         128'(ex.bsy));
      chk("xbar_cfg",     128'(xbar_cfg),     128'(ex.xbar));
      chk("pri_req_out",  128'(act_pri),      128'(ex.pri));
      chk("occupancy",    128'(act_occ),      128'(ex.occ));
    end
  end

  function automatic logic [N-1:0][N-1:0] rnd_dec();
    return (N*N)'($urandom);
  endfunction

  // Legal match: at most one grant per input and per output, only on queued cells.
  function automatic bit legal(input logic [N-1:0][N-1:0] d);
    for (int i = 0; i < N; i++) begin
      int rc = 0, cc = 0;
      for (int j = 0; j < N; j++) begin
        rc += int'(d[i][j]);
        cc += int'(d[j][i]);
        if (d[i][j] && mocc[i][j] == 0) return 1'b0;
      end
      if (rc > 1 || cc > 1) return 1'b0;
    end
    return 1'b1;
  endfunction

  function automatic logic [N-1:0][N-1:0] make_match();
    int p[N];
    logic [N-1:0][N-1:0] d = '0;
    for (int i = 0; i < N; i++) p[i] = i;
    for (int i = N - 1; i > 0; i--) begin
      int k = int'($urandom_range(0, i));
      int t = p[i];
      p[i] = p[k];
      p[k] = t;
    end
    for (int i = 0; i < N; i++)
      if (mocc[i][p[i]] > 0 && $urandom_range(0, 3) != 0) d[i][p[i]] = 1'b1;
    return d;
  endfunction

  // One clock: drive inputs, predict the outputs seen after the edge, queue them.
  task automatic tick(input bit en_v, input bit rdy_v, input logic [N-1:0][N-1:0] dec_v,
                      input bit apply, input bit snap, input bit nst, input bit nbsy,
                      input logic [N-1:0] xav, input logic [N-1:0][1:0] xad);
    exp_t                ex;
    logic [N-1:0]        av = xav;
    logic [N-1:0][1:0]   ad = xad;
    logic [N-1:0][N-1:0] dep = '0;
    if (amode == 1)
      for (int i = 0; i < N; i++)
        if ($urandom_range(0, 1) == 1) begin av[i] = 1'b1; ad[i] = 2'($urandom_range(0, 3)); end
    if (amode == 2) begin av[1] = 1'b1; ad[1] = 2'($urandom_range(0, 3)); end
    en = en_v; decision_ready = rdy_v; decision = dec_v; arr_valid = av; arr_dst = ad;
    ex = '0;
    if (!reset) begin
      mxbar = '0;
      for (int i = 0; i < N; i++)
        for (int j = 0; j < N; j++) begin mocc[i][j] = 0; msnap[i][j] = 0; end
    end else begin
      if (apply) begin
        if (legal(dec_v)) begin dep = dec_v; mxbar = dec_v; ex.xv = 1'b1; end
        else ex.err = 1'b1;
      end
      if (snap)
        for (int i = 0; i < N; i++)
          for (int j = 0; j < N; j++) msnap[i][j] = (mocc[i][j] > P - 1) ? P - 1 : mocc[i][j];
      for (int i = 0; i < N; i++)
        for (int j = 0; j < N; j++) begin
          bit a = av[i] && (int'(ad[i]) == j);
          bit d = dep[i][j];
          if (d && !a) mocc[i][j]--;
          else if (a && !d) begin
            if (mocc[i][j] == QD) ex.drop[i] = 1'b1;
            else mocc[i][j]++;
          end
        end
      ex.st = nst; ex.bsy = nbsy;
    end
    ex.xbar = mxbar;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        ex.pri[i*N+j] = C'(msnap[i][j]);
        ex.occ[i*N+j] = 5'(mocc[i][j]);
      end
    @(posedge clk);
    expq.push_back(ex);
    #1;
  endtask

  task automatic idle();
    tick(1'b0, 1'b1, rnd_dec(), 1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
  endtask

  // Full round: IDLE edge with en, LAUNCH, lat busy scheduler cycles, then the decision edge.
  task automatic round(input logic [N-1:0][N-1:0] dec, input bit auto_dec, input int lat,
                       input bit en_hold, input logic [N-1:0] aav, input logic [N-1:0][1:0] aad);
    logic [N-1:0][N-1:0] d;
    tick(1'b1, 1'b1, rnd_dec(), 1'b0, 1'b1, 1'b1, 1'b1, '0, '0);
    tick(en_hold, 1'b1, rnd_dec(), 1'b0, 1'b0, 1'b0, 1'b1, '0, '0);
    repeat (lat) tick(en_hold, 1'b0, rnd_dec(), 1'b0, 1'b0, 1'b0, 1'b1, '0, '0);
    d = auto_dec ? make_match() : dec;
    tick(en_hold, 1'b1, d, 1'b1, 1'b0, 1'b0, 1'b0, aav, aad);
  endtask

  initial begin
    logic [N-1:0][N-1:0] d;
    logic [N-1:0][1:0]   ad;
    amode = 0; reset = 1'b0; en = 1'b0; decision_ready = 1'b1; decision = '0;
    arr_valid = '0; arr_dst = '0; mxbar = '0;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin mocc[i][j] = 0; msnap[i][j] = 0; end

    repeat (2) tick(1'b0, 1'b1, rnd_dec(), 1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
    reset = 1'b1;
    idle();

    // Fill VOQ[0][1] with 3 cells and overfill VOQ[2][3].
    ad = '0; ad[0] = 2'd1; ad[2] = 2'd3;
    for (int k = 0; k < 20; k++)
      tick(1'b0, 1'b1, rnd_dec(), 1'b0, 1'b0, 1'b0, 1'b0, (k < 3) ? 4'b0101 : 4'b0100, ad);
    repeat (2) idle();
    chk("drop2_pulses", 128'(drop2_cnt), 128'(4));

    d = '0; d[0] = 4'b0010;
    round(d, 1'b0, 33, 1'b0, '0, '0);
    idle();

    d = '0; d[0] = 4'b0011;
    round(d, 1'b0, 2, 1'b0, '0, '0);
    d = '0; d[0] = 4'b0100; d[1] = 4'b0100;
    round(d, 1'b0, 2, 1'b0, '0, '0);
    d = '0; d[3] = 4'b0001;
    round(d, 1'b0, 2, 1'b0, '0, '0);
    idle();

    // Departure from the full VOQ[2][3] on the same edge as an arrival to it.
    d = '0; d[2] = 4'b1000;
    ad = '0; ad[2] = 2'd3;
    round(d, 1'b0, 1, 1'b0, 4'b0100, ad);
    idle();

    amode = 2;
    repeat (3) round('0, 1'b1, int'($urandom_range(0, 5)), 1'b1, '0, '0);
    idle();

    amode = 1;
    for (int r = 0; r < 10; r++) begin
      round(rnd_dec(), r[0], int'($urandom_range(0, 6)), 1'b0, '0, '0);
      repeat ($urandom_range(0, 2)) idle();
    end

    // Reset while waiting for the scheduler.
    amode = 0;
    tick(1'b1, 1'b1, rnd_dec(), 1'b0, 1'b1, 1'b1, 1'b1, '0, '0);
    tick(1'b0, 1'b1, rnd_dec(), 1'b0, 1'b0, 1'b0, 1'b1, '0, '0);
    repeat (3) tick(1'b0, 1'b0, rnd_dec(), 1'b0, 1'b0, 1'b0, 1'b1, '0, '0);
    reset = 1'b0;
    tick(1'b0, 1'b1, rnd_dec(), 1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
    reset = 1'b1;
    idle();
    amode = 1;
    repeat (3) round('0, 1'b1, int'($urandom_range(0, 4)), 1'b0, '0, '0);
    amode = 0;
    repeat (3) idle();

    @(negedge clk);
    #1;
    chk("queue_drained", 128'(expq.size()), 128'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/voq_req_gen.md
# voq_req_gen

Input-side front end for the priority iSLIP scheduler. It keeps one occupancy counter per virtual output queue (VOQ), turns occupancy into a C-bit request priority, and launches one scheduling round with a `start` pulse. It then waits for `decision_ready`, applies the returned N×N match by decrementing the matched VOQs, and drives the crossbar configuration. It produces the scheduler's `pri_req_in` and consumes its `decision` and `decision_ready`.

## Interface
- N, 4, number of input and output ports
- P, 16, number of priority levels; priority 0 means no request
- C, $clog2(P), priority width
- QD, 16, VOQ capacity in cells
- QW, $clog2(QD+1), occupancy counter width
- clk  in  1  clock; all state updates on the rising edge
- reset  in  1  synchronous, active-low reset
- en  in  1  allow a new scheduling round to launch
- arr_valid  in  [N-1:0]  cell arrival at input i this cycle
- arr_dst  in  [N-1:0][$clog2(N)-1:0]  destination output of the arrival at input i
- drop  out  [N-1:0]  1-cycle pulse: arrival at input i discarded because the VOQ was full
- pri_req_out  out  [C-1:0] [0:N-1][0:N-1]  registered request priority [input][output]; connects to scheduler `pri_req_in`
- start  out  1  1-cycle pulse that launches a scheduler round
- decision  in  [N-1:0][N-1:0]  scheduler match [input][output]
- decision_ready  in  1  scheduler idle, `decision` valid
- xbar_cfg  out  [N-1:0][N-1:0]  registered crossbar configuration; holds its value until the next apply
- xbar_valid  out  1  1-cycle pulse: `xbar_cfg` updated and one cell dequeued per set bit
- decision_err  out  1  1-cycle pulse: the match was rejected
- busy  out  1  high in LAUNCH and WAIT

## Operation
- State machine: IDLE, LAUNCH, WAIT.
  - IDLE: if `en`=1, load the snapshot into `pri_req_out` and go to LAUNCH; otherwise stay.
  - LAUNCH: `start`=1 for exactly this cycle; next state WAIT.
  - WAIT: when `decision_ready`=1, evaluate `decision` and go to IDLE; otherwise stay.
- Snapshot: `pri_req_out[i][j]` = min(occ[i][j], P-1).
  - Taken from the counter values before that edge's own arrivals.
  - Held constant through LAUNCH and WAIT, because the scheduler re-reads it every iteration.
- Arrivals are accepted in every state.
  - `arr_valid[i]` increments occ[i][arr_dst[i]].
  - At occ=QD the arrival is dropped: `drop[i]` pulses the next cycle and the count is unchanged.
- Match check in WAIT when `decision_ready`=1. The match is valid only if:
  - every row and every column has at most one set bit, and
  - every set bit has occ≥1.
- Valid match:
  - `xbar_cfg`<=`decision` and `xbar_valid` pulses.
  - Each matched VOQ is decremented by 1.
  - An all-zero match is legal: `xbar_valid` still pulses.
- Invalid match:
  - `decision_err` pulses.
  - `xbar_cfg` and the counters are unchanged and `xbar_valid` stays 0.
- Same-edge arrival and departure on one VOQ: the count is unchanged.
  - This applies even at occ=QD; no drop occurs.
- Counters never wrap. Overflow is prevented by the drop rule; underflow by the match check.

## Timing
- Reset (`reset`=0 at an edge) clears everything:
  - state returns to IDLE;
  - all occ, `pri_req_out`, `xbar_cfg` = 0;
  - `start`, `xbar_valid`, `drop`, `decision_err`, `busy` = 0.
- Reset wins over arrivals and decisions in the same cycle.
- Reset mid-round abandons the round. The scheduler shares the same reset.
- Round sequence, with edge E0 in IDLE and `en`=1:
  - E0: snapshot loaded.
  - Cycle after E0 (LAUNCH): `start`=1.
  - Edge E1 ending LAUNCH: the scheduler samples `start` and this block enters WAIT.
- `decision_ready` is ignored in LAUNCH, where it is still high from the scheduler's idle state. It is first sampled in WAIT.
- At the WAIT edge where `decision_ready`=1:
  - the apply happens on that edge;
  - `xbar_valid` or `decision_err` is high in the following cycle, with state back in IDLE.
- Minimum round-to-round spacing = 3 + scheduler latency cycles. The next snapshot is taken at the IDLE edge after the apply, so it already reflects the departures.
- `drop` is registered: it is high one cycle after the rejected arrival.

## Test plan
- Reset, then arrivals to VOQ[0][1] ×3 and VOQ[2][3] ×20 → occ 3 and 16 (QD); `drop[2]` pulses 4 times; after `en`, `pri_req_out[0][1]`=3 and `[2][3]`=15.
- One round with a scheduler model returning `decision[0]`=4'b0010 after 33 cycles → `start` is a single pulse; `pri_req_out` is stable through WAIT; `xbar_cfg[0]`=4'b0010; `xbar_valid` pulses once; occ[0][1] goes from 3 to 2.
- Invalid match: `decision[0]`=4'b0011, then column conflict rows 0 and 1 = 4'b0100, then a bit on an empty VOQ → `decision_err` pulses each time; counters and `xbar_cfg` unchanged.
- VOQ[2][3] at QD, arrival to it on the same edge as a matched departure → occ stays 16 and no `drop`.
- `en` held high for 3 rounds while input 1 receives arrivals every cycle → each snapshot reflects prior departures; no lost or double-counted cells (model counts equal RTL counts).
- `reset` driven low in WAIT → next cycle all outputs are 0 and state is IDLE; the next round starts cleanly from zero occupancy.
